// File: rtl/fpmul_r16_pkg.sv
// Shared types and helpers for the radix-16 shift-add mantissa multiplier.
// Latency: n/a (declarations only). Backpressure: n/a.
// Optional leading-zero output is enabled with `FPMUL_R16_LZCNT_EN.
package fpmul_r16_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} fpmul_r16_state_t;

   localparam int RADIX_BITS = 4;

   // Bits needed to hold a leading-zero count in the range 0..w inclusive.
   function automatic int lzc_w(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/fpmul_r16_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Instantiated by the multiplier only when `FPMUL_R16_LZCNT_EN is defined.
module fpmul_r16_lzc
   import fpmul_r16_pkg::*;
#(
   parameter int W  = 224,
   parameter int CW = lzc_w(W)
) (
   input  logic [W-1:0]  v,
   output logic [CW-1:0] cnt
);

   logic found;

   always_comb begin
      cnt   = CW'(W);
      found = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         if (!found && v[i]) begin
            cnt   = CW'(W - 1 - i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fpmulr16_seq.sv
// Radix-16 iterative unsigned multiplier: retires 4 multiplier bits per clock, 2*WID-bit product.
// Latency: WID/4 RUN cycles plus one FIN cycle; ld restarts at any time. No backpressure.
// `FPMUL_R16_LZCNT_EN adds a leading-zero count of the product, presented with done.
module fpmulr16_seq
   import fpmul_r16_pkg::*;
#(
   parameter int WID = 112
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld,
   input  logic [WID-1:0]   a,
   input  logic [WID-1:0]   b,
   output logic [2*WID-1:0] p,
   output logic             done,
   output logic             busy,
   output logic [7:0]       lzcnt
);

   localparam int STEPS = WID / RADIX_BITS;
   localparam int CNTW  = (STEPS > 1) ? $clog2(STEPS) : 1;

   if ((WID % RADIX_BITS) != 0 || WID > 127 || WID < RADIX_BITS) begin : g_bad_wid
      $fatal(1, "fpmulr16_seq: WID=%0d must be a multiple of 4 in 4..124", WID);
   end

   fpmul_r16_state_t   state;
   logic [2*WID-1:0]   prod;
   logic [WID-1:0]     a_r;
   logic [CNTW-1:0]    cnt;

   logic [3:0]         d;
   logic [WID+3:0]     ext_a;
   logic [WID+3:0]     pp;
   logic [WID+3:0]     sum;
   logic [2*WID-1:0]   prod_nxt;
   logic [7:0]         lz_nxt;

   assign d     = prod[3:0];
   assign ext_a = {4'b0000, a_r};

   // a_r*d as four conditionally shifted copies of a_r.
   always_comb begin
      pp = '0;
      for (int i = 0; i < RADIX_BITS; i++) begin
         if (d[i]) pp = pp + (ext_a << i);
      end
   end

   assign sum = {4'b0000, prod[2*WID-1:WID]} + pp;

   if (WID > RADIX_BITS) begin : g_shift
      assign prod_nxt = {sum, prod[WID-1:RADIX_BITS]};
   end else begin : g_shift_min
      assign prod_nxt = sum;
   end

`ifdef FPMUL_R16_LZCNT_EN
   logic [lzc_w(2*WID)-1:0] lz_raw;

   fpmul_r16_lzc #(.W(2*WID)) u_lzc (
      .v   (prod_nxt),
      .cnt (lz_raw)
   );

   assign lz_nxt = 8'(lz_raw);
`else
   assign lz_nxt = 8'd0;
`endif

   assign p = prod;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         prod  <= '0;
         a_r   <= '0;
         cnt   <= '0;
         done  <= 1'b0;
         busy  <= 1'b0;
         lzcnt <= 8'd0;
      end else if (ld) begin
         prod  <= {{WID{1'b0}}, b};
         a_r   <= a;
         cnt   <= CNTW'(STEPS - 1);
         state <= ST_RUN;
         busy  <= 1'b1;
         done  <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               prod <= prod_nxt;
               cnt  <= cnt - 1'b1;
               // Last step: the count is taken from the final product so it lines up with done.
               if (cnt == '0) begin
                  state <= ST_FIN;
                  done  <= 1'b1;
                  lzcnt <= lz_nxt;
               end
            end
            ST_FIN: begin
               state <= ST_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpmulr16_seq.sv
// Bench for fpmulr16_seq: WID=8 and WID=112 instances checked every cycle against a product/timing model.
// Build with or without `FPMUL_R16_LZCNT_EN; expected lzcnt follows the same macro.
module tb_fpmulr16_seq;

   logic clk = 1'b0;
   logic rst_n;

   logic          ld8;
   logic [7:0]    a8, b8;
   logic [15:0]   p8;
   logic          done8, busy8;
   logic [7:0]    lz8;

   logic          ld112;
   logic [111:0]  a112, b112;
   logic [223:0]  p112;
   logic          done112, busy112;
   logic [7:0]    lz112;

   always #5 clk = ~clk;

   fpmulr16_seq #(.WID(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .ld(ld8), .a(a8), .b(b8),
      .p(p8), .done(done8), .busy(busy8), .lzcnt(lz8)
   );

   fpmulr16_seq #(.WID(112)) u_dut112 (
      .clk(clk), .rst_n(rst_n), .ld(ld112), .a(a112), .b(b112),
      .p(p112), .done(done112), .busy(busy112), .lzcnt(lz112)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   bit           pend   [2];
   int           ldc    [2];
   int           dcnt   [2];
   logic [223:0] expp   [2];
   logic [7:0]   explz  [2];
   logic [223:0] hold   [2];
   logic [7:0]   holdlz [2];
   logic [223:0] lastp  [2];
   logic [7:0]   lastlz [2];

   task automatic chk(input string nm, input int k, input logic [223:0] got, input logic [223:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s dut=%0d cyc=%0d got=%h want=%h", nm, k, cyc, got, exp);
      end
   endtask

   function automatic int lzm(input logic [223:0] v, input int w);
      int  n = 0;
      bit  f = 0;
      for (int i = w - 1; i >= 0; i--) begin
         if (v[i]) f = 1;
         if (!f) n++;
      end
      return n;
   endfunction

   // Expected lzcnt output for a given true leading-zero count.
   function automatic logic [7:0] lzx(input int n);
`ifdef FPMUL_R16_LZCNT_EN
      return 8'(n);
`else
      return 8'd0 + 8'(n & 0);
`endif
   endfunction

   // Model: capture each accepted ld and the product/count the op must return.
   always @(posedge clk) begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
         logic          l;
         logic [223:0]  ea, eb;
         int            w;
         w  = (k == 0) ? 8 : 112;
         l  = (k == 0) ? ld8 : ld112;
         ea = (k == 0) ? 224'(a8) : 224'(a112);
         eb = (k == 0) ? 224'(b8) : 224'(b112);
         if (!rst_n) begin
            pend[k]   = 0;
            hold[k]   = '0;
            holdlz[k] = 8'd0;
         end else if (l) begin
            pend[k]  = 1;
            ldc[k]   = cyc;
            expp[k]  = ea * eb;
            explz[k] = lzx(lzm(ea * eb, 2 * w));
         end
      end
   end

   // Compare: outputs are settled half a cycle after the edge.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         logic [223:0] gp;
         logic         gd, gb;
         logic [7:0]   gl;
         int           st;
         bit           in_op, exp_done;
         st = (k == 0) ? 2 : 28;
         gp = (k == 0) ? 224'(p8) : p112;
         gd = (k == 0) ? done8 : done112;
         gb = (k == 0) ? busy8 : busy112;
         gl = (k == 0) ? lz8 : lz112;
         in_op    = pend[k] && (cyc <= ldc[k] + st);
         exp_done = pend[k] && (cyc == ldc[k] + st);
         chk("done", k, 224'(gd), 224'(exp_done));
         chk("busy", k, 224'(gb), 224'(in_op));
         if (exp_done) begin
            chk("p", k, gp, expp[k]);
            chk("lzcnt", k, 224'(gl), 224'(explz[k]));
            hold[k]   = expp[k];
            holdlz[k] = explz[k];
            pend[k]   = 0;
            lastp[k]  = gp;
            lastlz[k] = gl;
            dcnt[k]++;
         end else if (!in_op) begin
            chk("p_hold", k, gp, hold[k]);
            chk("lz_hold", k, 224'(gl), 224'(holdlz[k]));
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_done(input int k, input int prev);
      int n = 0;
      while (dcnt[k] == prev && n < 60) begin
         step();
         n++;
      end
      chk("done_seen", k, 224'(dcnt[k] != prev), 224'(1));
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b);
      int prev;
      prev = dcnt[0];
      ld8 = 1'b1; a8 = a; b8 = b;
      step();
      ld8 = 1'b0;
      wait_done(0, prev);
      step();
   endtask

   initial begin
      int prev;
      rst_n = 1'b0;
      ld8 = 1'b0; a8 = '0; b8 = '0;
      ld112 = 1'b0; a112 = '0; b112 = '0;
      for (int k = 0; k < 2; k++) begin
         pend[k] = 0; ldc[k] = 0; dcnt[k] = 0;
         hold[k] = '0; holdlz[k] = '0; lastp[k] = '0; lastlz[k] = '0;
         expp[k] = '0; explz[k] = '0;
      end
      repeat (3) step();
      rst_n = 1'b1;
      step();

      // Hand-computed points that pin the model.
      op8(8'hFF, 8'hFF);
      chk("t1_p", 0, lastp[0], 224'h0FE01);
      chk("t1_lz", 0, 224'(lastlz[0]), 224'(lzx(0)));
      op8(8'h01, 8'h01);
      chk("t2_p", 0, lastp[0], 224'h1);
      chk("t2_lz", 0, 224'(lastlz[0]), 224'(lzx(15)));
      op8(8'h00, 8'hA5);
      chk("t2_pz", 0, lastp[0], 224'h0);
      chk("t2_lzz", 0, 224'(lastlz[0]), 224'(lzx(16)));

      // Reset during the first RUN cycle must kill the op silently.
      prev = dcnt[0];
      ld8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      step();
      ld8 = 1'b0; rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (5) step();
      chk("t3_nodone", 0, 224'(dcnt[0]), 224'(prev));
      op8(8'd3, 8'd5);
      chk("t3_p", 0, lastp[0], 224'd15);
      chk("t3_lz", 0, 224'(lastlz[0]), 224'(lzx(12)));

      // Restart one cycle into an op: only the second op completes.
      prev = dcnt[0];
      ld8 = 1'b1; a8 = 8'd2; b8 = 8'd2;
      step();
      a8 = 8'h10; b8 = 8'h10;
      step();
      ld8 = 1'b0;
      wait_done(0, prev);
      repeat (5) step();
      chk("t4_single", 0, 224'(dcnt[0]), 224'(prev + 1));
      chk("t4_p", 0, lastp[0], 224'h0100);
      chk("t4_lz", 0, 224'(lastlz[0]), 224'(lzx(7)));

      // Random ld traffic on the narrow instance, including aborts and ld during FIN.
      for (int i = 0; i < 300; i++) begin
         ld8 = ($urandom_range(0, 3) == 0);
         a8  = 8'($urandom);
         b8  = 8'($urandom);
         step();
      end
      ld8 = 1'b0;
      repeat (6) step();

      // Wide instance: back-to-back ops, some issued in the FIN cycle of the previous one.
      for (int i = 0; i < 1000; i++) begin
         logic [111:0] ra, rb;
         ra = {$urandom, $urandom, $urandom, $urandom} >> $urandom_range(0, 111);
         rb = {$urandom, $urandom, $urandom, $urandom} >> $urandom_range(0, 111);
         if (i == 0) begin ra = '1; rb = '1; end
         if (i == 1) begin ra = '0; end
         prev = dcnt[1];
         ld112 = 1'b1; a112 = ra; b112 = rb;
         step();
         ld112 = 1'b0;
         wait_done(1, prev);
         repeat ($urandom_range(0, 2)) step();
      end
      repeat (4) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
